// File: rtl/z80_axil_master.sv
// z80_axil_master
//
// AXI4-Lite master for the Z80 bus-capture path. Each single-cycle fetch pulse becomes
// one AXI4-Lite read or write. axi_busy is held while a transaction is outstanding, and
// the CPU wrapper turns it into the Z80 WAIT line.
//
// Ports
//   AXI_CLK, RESETN      bus clock; asynchronous active-low reset
//   A, D, wstrb          request address, lane-placed write data, write strobes
//   rdaddr_fetch         one-cycle read request pulse
//   wraddr_fetch         one-cycle write request pulse (address)
//   wrdata_fetch         one-cycle write request pulse (data, coincident with wraddr_fetch)
//   axi_busy             registered "transaction outstanding" flag
//   read_data            byte lane A[1:0] of the last completed read
//   last_resp            RRESP/BRESP of the last completed transaction (2'b11 on timeout)
//   req_overrun          sticky: a fetch pulse arrived while busy
//   AXI_ar*/r*/aw*/w*/b* AXI4-Lite master channels, 32-bit data; prot tied to 0
//
// Optional feature (macro Z80_AXIL_TIMEOUT_EN): watchdog that aborts any transaction
// stuck in one state for TIMEOUT_CYCLES clocks. Without the macro the block waits forever.
// If a read and a write pulse arrive together, the write runs first and the read is queued.

module z80_axil_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        AXI_CLK,
    input  logic        RESETN,
    input  logic [31:0] A,
    input  logic [31:0] D,
    input  logic [3:0]  wstrb,
    input  logic        rdaddr_fetch,
    input  logic        wraddr_fetch,
    input  logic        wrdata_fetch,
    output logic        axi_busy,
    output logic [7:0]  read_data,
    output logic [1:0]  last_resp,
    output logic        req_overrun,
    output logic [31:0] AXI_araddr,
    output logic [2:0]  AXI_arprot,
    output logic        AXI_arvalid,
    input  logic        AXI_arready,
    input  logic [31:0] AXI_rdata,
    input  logic [1:0]  AXI_rresp,
    input  logic        AXI_rvalid,
    output logic        AXI_rready,
    output logic [31:0] AXI_awaddr,
    output logic [2:0]  AXI_awprot,
    output logic        AXI_awvalid,
    input  logic        AXI_awready,
    output logic [31:0] AXI_wdata,
    output logic [3:0]  AXI_wstrb,
    output logic        AXI_wvalid,
    input  logic        AXI_wready,
    input  logic [1:0]  AXI_bresp,
    input  logic        AXI_bvalid,
    output logic        AXI_bready
);

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdData,
        StWrAddrData,
        StWrResp
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [1:0]  lane_q, lane_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        busy_q, busy_d;
    logic [7:0]  read_data_q, read_data_d;
    logic [1:0]  last_resp_q, last_resp_d;
    logic        overrun_q, overrun_d;
    logic        fetch_any;
    logic        aw_done, w_done;

`ifdef Z80_AXIL_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    assign fetch_any = rdaddr_fetch | wraddr_fetch | wrdata_fetch;
    // A channel counts as complete once its valid has already dropped or handshakes now.
    assign aw_done   = !awvalid_q || AXI_awready;
    assign w_done    = !wvalid_q || AXI_wready;

    always_comb begin
        state_d     = state_q;
        araddr_d    = araddr_q;
        lane_d      = lane_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        read_data_d = read_data_q;
        last_resp_d = last_resp_q;
        overrun_d   = overrun_q;

        unique case (state_q)
            StIdle: begin
                if (pend_q) begin
                    // Queued read from a simultaneous read+write; new pulses are refused.
                    araddr_d  = {pend_addr_q[31:2], 2'b00};
                    lane_d    = pend_addr_q[1:0];
                    pend_d    = 1'b0;
                    arvalid_d = 1'b1;
                    state_d   = StRdAddr;
                    if (fetch_any) begin
                        overrun_d = 1'b1;
                    end
                end else if (wraddr_fetch) begin
                    awaddr_d  = A;
                    wdata_d   = D;
                    wstrb_d   = wstrb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = StWrAddrData;
                    if (rdaddr_fetch) begin
                        pend_d      = 1'b1;
                        pend_addr_d = A;
                    end
                end else if (rdaddr_fetch) begin
                    araddr_d  = {A[31:2], 2'b00};
                    lane_d    = A[1:0];
                    arvalid_d = 1'b1;
                    state_d   = StRdAddr;
                end
            end
            StRdAddr: begin
                if (AXI_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRdData;
                end
            end
            StRdData: begin
                if (AXI_rvalid) begin
                    read_data_d = AXI_rdata[{lane_q, 3'b000} +: 8];
                    last_resp_d = AXI_rresp;
                    rready_d    = 1'b0;
                    state_d     = StIdle;
                end
            end
            StWrAddrData: begin
                if (awvalid_q && AXI_awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && AXI_wready) begin
                    wvalid_d = 1'b0;
                end
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = StWrResp;
                end
            end
            StWrResp: begin
                if (AXI_bvalid) begin
                    last_resp_d = AXI_bresp;
                    bready_d    = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if ((state_q != StIdle) && fetch_any) begin
            overrun_d = 1'b1;
        end

`ifdef Z80_AXIL_TIMEOUT_EN
        cnt_d = '0;
        if (state_q != StIdle) begin
            if (state_d != state_q) begin
                cnt_d = '0;
            end else if (cnt_q == TIMEOUT_CYCLES - 1) begin
                if ((state_q == StRdAddr) || (state_q == StRdData)) begin
                    read_data_d = 8'hFF;
                end
                last_resp_d = 2'b11;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                pend_d      = 1'b0;
                state_d     = StIdle;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
`endif

        // Busy covers every non-idle cycle plus the cycle after the final handshake.
        busy_d = (state_q != StIdle) || (state_d != StIdle);
    end

    always_ff @(posedge AXI_CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= StIdle;
            araddr_q    <= '0;
            lane_q      <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            busy_q      <= 1'b0;
            read_data_q <= 8'h00;
            last_resp_q <= 2'b00;
            overrun_q   <= 1'b0;
`ifdef Z80_AXIL_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            araddr_q    <= araddr_d;
            lane_q      <= lane_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            busy_q      <= busy_d;
            read_data_q <= read_data_d;
            last_resp_q <= last_resp_d;
            overrun_q   <= overrun_d;
`ifdef Z80_AXIL_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign axi_busy    = busy_q;
    assign read_data   = read_data_q;
    assign last_resp   = last_resp_q;
    assign req_overrun = overrun_q;
    assign AXI_araddr  = araddr_q;
    assign AXI_arprot  = 3'b000;
    assign AXI_arvalid = arvalid_q;
    assign AXI_rready  = rready_q;
    assign AXI_awaddr  = awaddr_q;
    assign AXI_awprot  = 3'b000;
    assign AXI_awvalid = awvalid_q;
    assign AXI_wdata   = wdata_q;
    assign AXI_wstrb   = wstrb_q;
    assign AXI_wvalid  = wvalid_q;
    assign AXI_bready  = bready_q;

endmodule

// File: tb/tb_z80_axil_master.sv
// tb_z80_axil_master
//
// Self-checking bench for z80_axil_master: an AXI4-Lite slave with programmable per-channel
// delays, a protocol monitor, and a transaction-level reference model (expected byte, response,
// busy length, sticky overrun flag). The timeout scenario is compiled in with Z80_AXIL_TIMEOUT_EN.

module tb_z80_axil_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] D = '0;
    logic [3:0]  wstrb = '0;
    logic        rdaddr_fetch = 1'b0;
    logic        wraddr_fetch = 1'b0;
    logic        wrdata_fetch = 1'b0;
    logic        axi_busy;
    logic [7:0]  read_data;
    logic [1:0]  last_resp;
    logic        req_overrun;
    logic [31:0] AXI_araddr;
    logic [2:0]  AXI_arprot;
    logic        AXI_arvalid;
    logic        AXI_arready = 1'b0;
    logic [31:0] AXI_rdata = '0;
    logic [1:0]  AXI_rresp = '0;
    logic        AXI_rvalid = 1'b0;
    logic        AXI_rready;
    logic [31:0] AXI_awaddr;
    logic [2:0]  AXI_awprot;
    logic        AXI_awvalid;
    logic        AXI_awready = 1'b0;
    logic [31:0] AXI_wdata;
    logic [3:0]  AXI_wstrb;
    logic        AXI_wvalid;
    logic        AXI_wready = 1'b0;
    logic [1:0]  AXI_bresp = '0;
    logic        AXI_bvalid = 1'b0;
    logic        AXI_bready;

    z80_axil_master #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .AXI_CLK     (clk),
        .RESETN      (rst_n),
        .A           (A),
        .D           (D),
        .wstrb       (wstrb),
        .rdaddr_fetch(rdaddr_fetch),
        .wraddr_fetch(wraddr_fetch),
        .wrdata_fetch(wrdata_fetch),
        .axi_busy    (axi_busy),
        .read_data   (read_data),
        .last_resp   (last_resp),
        .req_overrun (req_overrun),
        .AXI_araddr  (AXI_araddr),
        .AXI_arprot  (AXI_arprot),
        .AXI_arvalid (AXI_arvalid),
        .AXI_arready (AXI_arready),
        .AXI_rdata   (AXI_rdata),
        .AXI_rresp   (AXI_rresp),
        .AXI_rvalid  (AXI_rvalid),
        .AXI_rready  (AXI_rready),
        .AXI_awaddr  (AXI_awaddr),
        .AXI_awprot  (AXI_awprot),
        .AXI_awvalid (AXI_awvalid),
        .AXI_awready (AXI_awready),
        .AXI_wdata   (AXI_wdata),
        .AXI_wstrb   (AXI_wstrb),
        .AXI_wvalid  (AXI_wvalid),
        .AXI_wready  (AXI_wready),
        .AXI_bresp   (AXI_bresp),
        .AXI_bvalid  (AXI_bvalid),
        .AXI_bready  (AXI_bready)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    // Slave configuration for the next transaction.
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_rresp = '0, cfg_bresp = '0;

    // Slave observations.
    logic [31:0] obs_araddr = '0, obs_awaddr = '0, obs_wdata = '0;
    logic [3:0]  obs_wstrb = '0;
    int          n_ar = 0, n_aw = 0, n_w = 0, n_b = 0, proto_err = 0;

    // Slave internal state.
    int          s_ar_cnt, s_aw_cnt, s_w_cnt, s_r_cnt, s_b_cnt;
    bit          s_ar_fire, s_aw_fire, s_w_fire, s_r_fire, s_b_fire;
    bit          s_r_pend, s_b_pend, s_aw_done, s_w_done;
    bit          s_ar_hold, s_aw_hold, s_w_hold;
    logic [31:0] s_ar_last, s_aw_last, s_wd_last;

    // Scoreboard.
    int          n_checks = 0, n_fail = 0;
    logic [7:0]  model_rd = 8'h00;
    logic [1:0]  model_resp = 2'b00;
    logic        model_ovr = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // AXI4-Lite slave and protocol monitor; all driving happens on the falling edge.
    initial begin : slave
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                AXI_arready = 1'b0; AXI_awready = 1'b0; AXI_wready = 1'b0;
                AXI_rvalid = 1'b0; AXI_bvalid = 1'b0;
                s_ar_cnt = 0; s_aw_cnt = 0; s_w_cnt = 0; s_r_cnt = 0; s_b_cnt = 0;
                s_ar_fire = 0; s_aw_fire = 0; s_w_fire = 0; s_r_fire = 0; s_b_fire = 0;
                s_r_pend = 0; s_b_pend = 0; s_aw_done = 0; s_w_done = 0;
                s_ar_hold = 0; s_aw_hold = 0; s_w_hold = 0;
            end else begin
                if (s_ar_hold && AXI_arvalid && AXI_araddr != s_ar_last) proto_err++;
                if (s_aw_hold && AXI_awvalid && AXI_awaddr != s_aw_last) proto_err++;
                if (s_w_hold && AXI_wvalid && AXI_wdata != s_wd_last) proto_err++;
`ifndef Z80_AXIL_TIMEOUT_EN
                if ((s_ar_hold && !AXI_arvalid) || (s_aw_hold && !AXI_awvalid) ||
                    (s_w_hold && !AXI_wvalid)) proto_err++;
`endif
                if (AXI_arvalid && (AXI_awvalid || AXI_wvalid || AXI_bready)) proto_err++;

                if (s_ar_fire) begin
                    s_ar_fire = 0; AXI_arready = 1'b0; n_ar++; s_r_pend = 1; s_r_cnt = r_dly;
                end
                if (s_aw_fire) begin
                    s_aw_fire = 0; AXI_awready = 1'b0; n_aw++; s_aw_done = 1;
                end
                if (s_w_fire) begin
                    s_w_fire = 0; AXI_wready = 1'b0; n_w++; s_w_done = 1;
                end
                if (s_r_fire) begin
                    s_r_fire = 0; AXI_rvalid = 1'b0;
                end
                if (s_b_fire) begin
                    s_b_fire = 0; AXI_bvalid = 1'b0; n_b++;
                end
                if (s_aw_done && s_w_done) begin
                    s_aw_done = 0; s_w_done = 0; s_b_pend = 1; s_b_cnt = b_dly;
                end

                if (AXI_arvalid && !AXI_arready) begin
                    if (s_ar_cnt >= ar_dly) begin
                        AXI_arready = 1'b1; obs_araddr = AXI_araddr; s_ar_cnt = 0;
                    end else s_ar_cnt++;
                end else if (!AXI_arvalid) s_ar_cnt = 0;
                if (AXI_awvalid && !AXI_awready) begin
                    if (s_aw_cnt >= aw_dly) begin
                        AXI_awready = 1'b1; obs_awaddr = AXI_awaddr; s_aw_cnt = 0;
                    end else s_aw_cnt++;
                end else if (!AXI_awvalid) s_aw_cnt = 0;
                if (AXI_wvalid && !AXI_wready) begin
                    if (s_w_cnt >= w_dly) begin
                        AXI_wready = 1'b1; obs_wdata = AXI_wdata; obs_wstrb = AXI_wstrb;
                        s_w_cnt = 0;
                    end else s_w_cnt++;
                end else if (!AXI_wvalid) s_w_cnt = 0;
                if (s_r_pend) begin
                    if (s_r_cnt == 0) begin
                        AXI_rvalid = 1'b1; AXI_rdata = cfg_rdata; AXI_rresp = cfg_rresp;
                        s_r_pend = 0;
                    end else s_r_cnt--;
                end
                if (s_b_pend) begin
                    if (s_b_cnt == 0) begin
                        AXI_bvalid = 1'b1; AXI_bresp = cfg_bresp; s_b_pend = 0;
                    end else s_b_cnt--;
                end

                s_ar_fire = AXI_arvalid && AXI_arready;
                s_aw_fire = AXI_awvalid && AXI_awready;
                s_w_fire  = AXI_wvalid && AXI_wready;
                s_r_fire  = AXI_rvalid && AXI_rready;
                s_b_fire  = AXI_bvalid && AXI_bready;
                s_ar_hold = AXI_arvalid && !AXI_arready;
                s_aw_hold = AXI_awvalid && !AXI_awready;
                s_w_hold  = AXI_wvalid && !AXI_wready;
                s_ar_last = AXI_araddr;
                s_aw_last = AXI_awaddr;
                s_wd_last = AXI_wdata;
            end
        end
    end

    // Pulse a request, then count busy cycles; optionally pulse a read at busy cycle inject_at.
    task automatic run_txn(input bit do_rd, input bit do_wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb,
                           input int inject_at, output int busy_cycles);
        @(negedge clk);
        A = addr; D = data; wstrb = strb;
        rdaddr_fetch = do_rd; wraddr_fetch = do_wr; wrdata_fetch = do_wr;
        @(negedge clk);
        rdaddr_fetch = 1'b0; wraddr_fetch = 1'b0; wrdata_fetch = 1'b0;
        busy_cycles = 0;
        while (axi_busy && busy_cycles < 200) begin
            busy_cycles++;
            rdaddr_fetch = (busy_cycles == inject_at);
            @(negedge clk);
        end
        rdaddr_fetch = 1'b0;
    endtask

    task automatic txn_and_check(input bit do_rd, input bit do_wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb,
                                 input int inject_at);
        int          busy, exp_busy, ar0, b0;
        logic [31:0] shifted;
        ar0 = n_ar;
        b0  = n_b;
        run_txn(do_rd, do_wr, addr, data, strb, inject_at, busy);
        exp_busy = 0;
        if (do_wr) exp_busy += 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
        if (do_rd) exp_busy += 3 + ar_dly + r_dly;
        check_eq("busy_cycles", busy, exp_busy);
        if (do_rd) begin
            shifted  = cfg_rdata >> (8 * addr[1:0]);
            model_rd = shifted[7:0];
            check_eq("araddr", obs_araddr, addr & 32'hFFFF_FFFC);
        end
        check_eq("ar_count", n_ar - ar0, do_rd ? 1 : 0);
        if (do_wr) begin
            check_eq("awaddr", obs_awaddr, addr);
            check_eq("wdata", obs_wdata, data);
            check_eq("wstrb", {28'd0, obs_wstrb}, {28'd0, strb});
        end
        check_eq("b_count", n_b - b0, do_wr ? 1 : 0);
        model_resp = do_rd ? cfg_rresp : cfg_bresp;
        if (inject_at > 0) model_ovr = 1'b1;
        check_eq("read_data", {24'd0, read_data}, {24'd0, model_rd});
        check_eq("last_resp", {30'd0, last_resp}, {30'd0, model_resp});
        check_eq("req_overrun", {31'd0, req_overrun}, {31'd0, model_ovr});
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_busy"}, {31'd0, axi_busy}, 32'd0);
        check_eq({tag, "_valids"}, {27'd0, AXI_arvalid, AXI_rready, AXI_awvalid, AXI_wvalid,
                 AXI_bready}, 32'd0);
        check_eq({tag, "_araddr"}, AXI_araddr, 32'd0);
        check_eq({tag, "_awaddr"}, AXI_awaddr, 32'd0);
        check_eq({tag, "_wdata"}, AXI_wdata, 32'd0);
        check_eq({tag, "_wstrb"}, {28'd0, AXI_wstrb}, 32'd0);
        check_eq({tag, "_status"}, {21'd0, read_data, last_resp, req_overrun}, 32'd0);
    endtask

    task automatic set_delays(input int ar, input int r, input int aw, input int w,
                              input int b);
        ar_dly = ar; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int          kind, inj, exp_single, cyc;
        bit          do_rd, do_wr;
        logic [31:0] addr, data;
        logic [3:0]  strb;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Aligned-lane read, slave immediate.
        set_delays(0, 0, 0, 0, 0);
        cfg_rdata = 32'hAABB_CCDD; cfg_rresp = 2'b00;
        txn_and_check(1, 0, 32'h4000_0002, '0, '0, 0);
        check_eq("read_byte_bb", {24'd0, read_data}, 32'h0000_00BB);

        // Write with AW delayed 4 cycles; W completes first.
        set_delays(0, 0, 4, 0, 0);
        cfg_bresp = 2'b00;
        txn_and_check(0, 1, 32'h4000_0001, 32'h0000_5A00, 4'b0010, 0);

        // Simultaneous read and write: write first, then queued read; 6 busy cycles.
        set_delays(0, 0, 0, 0, 0);
        cfg_rdata = 32'h1122_3344;
        txn_and_check(1, 1, 32'h4000_0103, 32'h7700_0000, 4'b1000, 0);

        // Read pulse during WR_RESP is dropped and sets the sticky overrun flag.
        set_delays(0, 0, 0, 0, 3);
        txn_and_check(0, 1, 32'h4000_0200, 32'h0000_00A5, 4'b0001, 2);
        set_delays(0, 0, 0, 0, 0);
        txn_and_check(1, 0, 32'h4000_0204, '0, '0, 0);
        txn_and_check(0, 1, 32'h4000_0208, 32'h0012_0000, 4'b0100, 0);

        // SLVERR on read still updates the byte.
        cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b10;
        txn_and_check(1, 0, 32'h4000_0301, '0, '0, 0);

        // Randomised transactions with random slave timing and responses.
        for (int i = 0; i < 40; i++) begin
            kind  = $urandom_range(2, 0);
            do_rd = (kind != 1);
            do_wr = (kind != 0);
            set_delays($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                       $urandom_range(3, 0), $urandom_range(3, 0));
            cfg_rdata = $urandom;
            cfg_rresp = 2'($urandom_range(3, 0));
            cfg_bresp = 2'($urandom_range(3, 0));
            addr = $urandom; data = $urandom; strb = 4'($urandom_range(15, 0));
            inj = 0;
            if (kind != 2 && $urandom_range(3, 0) == 0) begin
                exp_single = do_rd ? (3 + ar_dly + r_dly)
                                   : (3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly);
                inj = $urandom_range(exp_single - 1, 1);
            end
            txn_and_check(do_rd, do_wr, addr, data, strb, inj);
        end

`ifdef Z80_AXIL_TIMEOUT_EN
        // Slave never accepts AR: watchdog aborts after TIMEOUT_CYCLES (16).
        set_delays(1000, 0, 0, 0, 0);
        @(negedge clk);
        A = 32'h4000_0400; rdaddr_fetch = 1'b1;
        @(negedge clk);
        rdaddr_fetch = 1'b0;
        cyc = 0;
        while (AXI_arvalid && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check_eq("timeout_arvalid_cycles", cyc, 16);
        cyc = 0;
        while (axi_busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check_eq("timeout_busy_cleared", {31'd0, axi_busy}, 32'd0);
        model_rd = 8'hFF; model_resp = 2'b11;
        check_eq("timeout_read_data", {24'd0, read_data}, 32'h0000_00FF);
        check_eq("timeout_last_resp", {30'd0, last_resp}, 32'd3);
`else
        cyc = 0;
`endif

        // Reset asserted mid-read restores every output to its reset value.
        set_delays(5, 0, 0, 0, 0);
        cfg_rdata = 32'h0102_0304; cfg_rresp = 2'b01;
        @(negedge clk);
        A = 32'h4000_0500; rdaddr_fetch = 1'b1;
        @(negedge clk);
        rdaddr_fetch = 1'b0;
        @(negedge clk);
        check_eq("midreset_precondition", {31'd0, AXI_arvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        model_rd = 8'h00; model_resp = 2'b00; model_ovr = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Block operates normally after reset.
        set_delays(1, 1, 0, 0, 0);
        cfg_rdata = 32'hCAFE_F00D; cfg_rresp = 2'b00;
        txn_and_check(1, 0, 32'h4000_0600, '0, '0, 0);

        check_eq("prot_tied_zero", {26'd0, AXI_arprot, AXI_awprot}, 32'd0);
        check_eq("protocol_errors", proto_err, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
